// File: rtl/control_unit_pkg.sv
// Shared processor definitions: opcode constants, step-state encoding and the
// decoded-class / control-strobe bundles used by the control unit and datapath.
package control_unit_pkg;

    localparam logic [4:0] OP_LD   = 5'd0;
    localparam logic [4:0] OP_LDI  = 5'd1;
    localparam logic [4:0] OP_ST   = 5'd2;
    localparam logic [4:0] OP_ADD  = 5'd3;
    localparam logic [4:0] OP_SUB  = 5'd4;
    localparam logic [4:0] OP_AND  = 5'd9;
    localparam logic [4:0] OP_OR   = 5'd10;
    localparam logic [4:0] OP_ADDI = 5'd11;
    localparam logic [4:0] OP_ANDI = 5'd12;
    localparam logic [4:0] OP_ORI  = 5'd13;
    localparam logic [4:0] OP_NOP  = 5'd25;
    localparam logic [4:0] OP_HALT = 5'd26;

    typedef enum logic [3:0] {
        ST_T0    = 4'd0,
        ST_T1    = 4'd1,
        ST_T2    = 4'd2,
        ST_T3    = 4'd3,
        ST_T4    = 4'd4,
        ST_T5    = 4'd5,
        ST_T6    = 4'd6,
        ST_T7    = 4'd7,
        ST_PAUSE = 4'd8,
        ST_HALT  = 4'd9
    } state_t;

    // alu_op is one-hot in the order {add, sub, and, or}
    typedef struct packed {
        logic       ld;
        logic       ldi;
        logic       st;
        logic       alu_reg;
        logic       alu_imm;
        logic       nop;
        logic       halt;
        logic [3:0] alu_op;
    } op_class_t;

    typedef struct packed {
        logic pc_out;
        logic pc_in;
        logic inc_pc;
        logic mar_in;
        logic mdr_in;
        logic mdr_out;
        logic read;
        logic write;
        logic ir_in;
        logic gra;
        logic grb;
        logic grc;
        logic r_in;
        logic r_out;
        logic ba_out;
        logic y_in;
        logic z_in;
        logic zlow_out;
        logic c_out;
        logic alu_add;
        logic alu_sub;
        logic alu_and;
        logic alu_or;
        logic run;
    } ctrl_t;

endpackage

// File: rtl/control_unit_op_decode.sv
// Combinational opcode classifier; undefined opcodes fall into the nop class.
module op_decode
    import control_unit_pkg::*;
(
    input  logic [4:0] opcode,
    output op_class_t  cls
);

    always_comb begin
        cls = '0;
        case (opcode)
            OP_LD:   cls.ld = 1'b1;
            OP_LDI:  cls.ldi = 1'b1;
            OP_ST:   cls.st = 1'b1;
            OP_ADD:  begin cls.alu_reg = 1'b1; cls.alu_op = 4'b1000; end
            OP_SUB:  begin cls.alu_reg = 1'b1; cls.alu_op = 4'b0100; end
            OP_AND:  begin cls.alu_reg = 1'b1; cls.alu_op = 4'b0010; end
            OP_OR:   begin cls.alu_reg = 1'b1; cls.alu_op = 4'b0001; end
            OP_ADDI: begin cls.alu_imm = 1'b1; cls.alu_op = 4'b1000; end
            OP_ANDI: begin cls.alu_imm = 1'b1; cls.alu_op = 4'b0010; end
            OP_ORI:  begin cls.alu_imm = 1'b1; cls.alu_op = 4'b0001; end
            OP_HALT: cls.halt = 1'b1;
            default: cls.nop = 1'b1;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Moore step sequencer for the bus-based processor: fetch in T0-T2, per-class
// execute steps from T3, with PAUSE (stop request) and HALT (reset-only exit).
module control_unit
    import control_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] ir,
    input  logic        stop,
    output logic        PCout,
    output logic        PCin,
    output logic        IncPC,
    output logic        MARin,
    output logic        MDRin,
    output logic        MDRout,
    output logic        Read,
    output logic        Write,
    output logic        IRin,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        BAout,
    output logic        Yin,
    output logic        Zin,
    output logic        Zlowout,
    output logic        Cout,
    output logic        ADD,
    output logic        SUB,
    output logic        AND,
    output logic        OR,
    output logic        run
);

    state_t    state_reg, state_next;
    op_class_t cls;
    ctrl_t     ctrl;
    logic      last_step;
    logic      unused_ir;

    assign unused_ir = ^ir[26:0];

    op_decode u_op_decode (
        .opcode (ir[31:27]),
        .cls    (cls)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= ST_T0;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = ST_T0;
        last_step  = 1'b0;
        case (state_reg)
            ST_T0:    state_next = ST_T1;
            ST_T1:    state_next = ST_T2;
            ST_T2:    state_next = ST_T3;
            ST_T3: begin
                if (cls.halt)     state_next = ST_HALT;
                else if (cls.nop) last_step  = 1'b1;
                else              state_next = ST_T4;
            end
            ST_T4:    state_next = ST_T5;
            ST_T5: begin
                if (cls.ld || cls.st) state_next = ST_T6;
                else                  last_step  = 1'b1;
            end
            ST_T6: begin
                if (cls.ld) state_next = ST_T7;
                else        last_step  = 1'b1;
            end
            ST_T7:    last_step  = 1'b1;
            ST_PAUSE: state_next = stop ? ST_PAUSE : ST_T0;
            ST_HALT:  state_next = ST_HALT;
            default:  state_next = ST_T0;
        endcase
        // stop only matters at an instruction boundary
        if (last_step) state_next = stop ? ST_PAUSE : ST_T0;
    end

    // Strobes are forced low combinationally while reset is held
    always_comb begin
        ctrl     = '0;
        ctrl.run = 1'b1;
        if (rst_n) begin
            case (state_reg)
                ST_T0: begin
                    ctrl.pc_out = 1'b1; ctrl.mar_in = 1'b1;
                    ctrl.inc_pc = 1'b1; ctrl.z_in   = 1'b1;
                end
                ST_T1: begin
                    ctrl.zlow_out = 1'b1; ctrl.pc_in  = 1'b1;
                    ctrl.read     = 1'b1; ctrl.mdr_in = 1'b1;
                end
                ST_T2: begin
                    ctrl.mdr_out = 1'b1; ctrl.ir_in = 1'b1;
                end
                ST_T3: begin
                    if (cls.ld || cls.ldi || cls.st) begin
                        ctrl.grb = 1'b1; ctrl.ba_out = 1'b1; ctrl.y_in = 1'b1;
                    end else if (cls.alu_reg || cls.alu_imm) begin
                        ctrl.grb = 1'b1; ctrl.r_out = 1'b1; ctrl.y_in = 1'b1;
                    end else if (cls.halt) begin
                        ctrl.run = 1'b0;
                    end
                end
                ST_T4: begin
                    if (cls.ld || cls.ldi || cls.st) begin
                        ctrl.c_out = 1'b1; ctrl.alu_add = 1'b1; ctrl.z_in = 1'b1;
                    end else if (cls.alu_reg || cls.alu_imm) begin
                        ctrl.z_in  = 1'b1;
                        ctrl.c_out = cls.alu_imm;
                        ctrl.grc   = cls.alu_reg;
                        ctrl.r_out = cls.alu_reg;
                        {ctrl.alu_add, ctrl.alu_sub, ctrl.alu_and, ctrl.alu_or} = cls.alu_op;
                    end
                end
                ST_T5: begin
                    if (cls.ld || cls.st) begin
                        ctrl.zlow_out = 1'b1; ctrl.mar_in = 1'b1;
                    end else if (cls.ldi || cls.alu_reg || cls.alu_imm) begin
                        ctrl.zlow_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1;
                    end
                end
                ST_T6: begin
                    if (cls.ld) begin
                        ctrl.read = 1'b1; ctrl.mdr_in = 1'b1;
                    end else if (cls.st) begin
                        ctrl.write = 1'b1; ctrl.gra    = 1'b1;
                        ctrl.r_out = 1'b1; ctrl.mdr_in = 1'b1;
                    end
                end
                ST_T7: begin
                    if (cls.ld) begin
                        ctrl.mdr_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1;
                    end
                end
                ST_PAUSE, ST_HALT: ctrl.run = 1'b0;
                default: ;
            endcase
        end
    end

    assign PCout   = ctrl.pc_out;
    assign PCin    = ctrl.pc_in;
    assign IncPC   = ctrl.inc_pc;
    assign MARin   = ctrl.mar_in;
    assign MDRin   = ctrl.mdr_in;
    assign MDRout  = ctrl.mdr_out;
    assign Read    = ctrl.read;
    assign Write   = ctrl.write;
    assign IRin    = ctrl.ir_in;
    assign Gra     = ctrl.gra;
    assign Grb     = ctrl.grb;
    assign Grc     = ctrl.grc;
    assign Rin     = ctrl.r_in;
    assign Rout    = ctrl.r_out;
    assign BAout   = ctrl.ba_out;
    assign Yin     = ctrl.y_in;
    assign Zin     = ctrl.z_in;
    assign Zlowout = ctrl.zlow_out;
    assign Cout    = ctrl.c_out;
    assign ADD     = ctrl.alu_add;
    assign SUB     = ctrl.alu_sub;
    assign AND     = ctrl.alu_and;
    assign OR      = ctrl.alu_or;
    assign run     = ctrl.run;

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: a behavioural datapath executes the strobes (and feeds
// ir back), while a scoreboard queue holds the expected strobe vector per cycle.
module tb_control_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] ir_reg = 32'd0;
    logic        stop = 1'b0;
    logic PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, Write, IRin;
    logic Gra, Grb, Grc, Rin, Rout, BAout, Yin, Zin, Zlowout, Cout;
    logic ADD, SUB, AND, OR, run;

    always #5 clk = ~clk;

    control_unit dut (
        .clk(clk), .rst_n(rst_n), .ir(ir_reg), .stop(stop),
        .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .MDRin(MDRin),
        .MDRout(MDRout), .Read(Read), .Write(Write), .IRin(IRin),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
        .Yin(Yin), .Zin(Zin), .Zlowout(Zlowout), .Cout(Cout),
        .ADD(ADD), .SUB(SUB), .AND(AND), .OR(OR), .run(run)
    );

    localparam logic [23:0] K_PCOUT = 24'h800000, K_PCIN  = 24'h400000, K_INCPC = 24'h200000;
    localparam logic [23:0] K_MARIN = 24'h100000, K_MDRIN = 24'h080000, K_MDROUT = 24'h040000;
    localparam logic [23:0] K_READ  = 24'h020000, K_WRITE = 24'h010000, K_IRIN  = 24'h008000;
    localparam logic [23:0] K_GRA   = 24'h004000, K_GRB   = 24'h002000, K_GRC   = 24'h001000;
    localparam logic [23:0] K_RIN   = 24'h000800, K_ROUT  = 24'h000400, K_BAOUT = 24'h000200;
    localparam logic [23:0] K_YIN   = 24'h000100, K_ZIN   = 24'h000080, K_ZLOW  = 24'h000040;
    localparam logic [23:0] K_COUT  = 24'h000020, K_ADD   = 24'h000010, K_SUB   = 24'h000008;
    localparam logic [23:0] K_AND   = 24'h000004, K_OR    = 24'h000002, K_RUN   = 24'h000001;
    localparam logic [23:0] K_IDLE  = 24'h000000;

    localparam logic [23:0] F0 = K_PCOUT | K_MARIN | K_INCPC | K_ZIN | K_RUN;
    localparam logic [23:0] F1 = K_ZLOW | K_PCIN | K_READ | K_MDRIN | K_RUN;
    localparam logic [23:0] F2 = K_MDROUT | K_IRIN | K_RUN;
    localparam logic [23:0] M3 = K_GRB | K_BAOUT | K_YIN | K_RUN;
    localparam logic [23:0] M4 = K_COUT | K_ADD | K_ZIN | K_RUN;
    localparam logic [23:0] M5 = K_ZLOW | K_MARIN | K_RUN;
    localparam logic [23:0] ST6 = K_WRITE | K_GRA | K_ROUT | K_MDRIN | K_RUN;
    localparam logic [23:0] LD6 = K_READ | K_MDRIN | K_RUN;
    localparam logic [23:0] LD7 = K_MDROUT | K_GRA | K_RIN | K_RUN;
    localparam logic [23:0] A3 = K_GRB | K_ROUT | K_YIN | K_RUN;
    localparam logic [23:0] A5 = K_ZLOW | K_GRA | K_RIN | K_RUN;

    logic [23:0] obs;
    assign obs = {PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, Write, IRin,
                  Gra, Grb, Grc, Rin, Rout, BAout, Yin, Zin, Zlowout, Cout,
                  ADD, SUB, AND, OR, run};

    // Behavioural datapath state, owned solely by the initial block's process
    logic [31:0] pc, mar, mdr, y, z;
    logic [31:0] regs [16];
    logic [31:0] mem [256];

    logic [23:0] vec_q [$];
    string       tag_q [$];
    int          n_vec = 0;
    int          n_mis = 0;

    function automatic logic [31:0] mk(input logic [4:0] op, input logic [3:0] ra,
                                       input logic [3:0] rb, input logic [3:0] rc,
                                       input logic [14:0] c);
        return {op, ra, rb, rc, c};
    endfunction

    task automatic push(input string tag, input logic [23:0] v);
        tag_q.push_back(tag);
        vec_q.push_back(v);
    endtask

    // Apply the strobes seen this cycle to the datapath just after the next edge
    task automatic dp_step();
        logic [3:0]  sel;
        logic [31:0] cext, bus, alu, n_pc, n_mar, n_mdr, n_ir, n_y, n_z;
        logic        wr_mem, wr_reg;
        logic [7:0]  wa;
        cext = {{13{ir_reg[18]}}, ir_reg[18:0]};
        sel  = Gra ? ir_reg[26:23] : (Grb ? ir_reg[22:19] : ir_reg[18:15]);
        bus  = 32'd0;
        if (PCout)        bus = pc;
        else if (MDRout)  bus = mdr;
        else if (Zlowout) bus = z;
        else if (Rout)    bus = regs[sel];
        else if (BAout)   bus = (sel == 4'd0) ? 32'd0 : regs[sel];
        else if (Cout)    bus = cext;
        alu = IncPC ? bus + 32'd1 : ADD ? y + bus : SUB ? y - bus :
              AND ? (y & bus) : OR ? (y | bus) : bus;
        n_pc  = PCin  ? bus : pc;
        n_mar = MARin ? bus : mar;
        n_mdr = MDRin ? (Read ? mem[mar[7:0]] : bus) : mdr;
        n_ir  = IRin  ? bus : ir_reg;
        n_y   = Yin   ? bus : y;
        n_z   = Zin   ? alu : z;
        wr_mem = Write;
        wr_reg = Rin;
        wa     = mar[7:0];
        @(posedge clk);
        #1;
        pc = n_pc; mar = n_mar; mdr = n_mdr; ir_reg = n_ir; y = n_y; z = n_z;
        if (wr_mem) mem[wa] = bus;
        if (wr_reg) regs[sel] = bus;
    endtask

    // Scoreboard consumer: one expected vector and one exclusivity check per cycle
    task automatic drain(input int n);
        logic [23:0] e;
        string       t;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            n_vec++;
            if (vec_q.size() == 0) begin
                n_mis++;
                $display("FAIL scoreboard_underflow: got %06h required a queued vector", obs);
            end else begin
                e = vec_q.pop_front();
                t = tag_q.pop_front();
                $display("%8t %-12s strobes=%06h expected=%06h", $time, t, obs, e);
                if (obs !== e) begin
                    n_mis++;
                    $display("FAIL %s: strobes=%06h required=%06h", t, obs, e);
                end
            end
            n_vec++;
            if ($countones({Rout, BAout, PCout, MDRout, Zlowout, Cout}) > 1) begin
                n_mis++;
                $display("FAIL bus_exclusive: drivers=%06b required at most one",
                         {Rout, BAout, PCout, MDRout, Zlowout, Cout});
            end
            dp_step();
        end
    endtask

    // Asynchronous reset pulse between edges; leaves the DUT in T0 before a negedge
    task automatic do_reset(input logic [31:0] start_pc);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        pc = start_pc; mar = 32'd0; mdr = 32'd0; y = 32'd0; z = 32'd0; ir_reg = 32'd0;
        stop = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        #1;
        n_vec++;
        if (obs !== K_RUN) begin
            n_mis++;
            $display("FAIL reset_async: strobes=%06h required=%06h", obs, K_RUN);
        end
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if (obs !== K_RUN) begin
            n_mis++;
            $display("FAIL reset_held: strobes=%06h required=%06h", obs, K_RUN);
        end
        rst_n = 1'b1;
        #1;
        n_vec++;
        if (obs !== F0) begin
            n_mis++;
            $display("FAIL reset_release_t0: strobes=%06h required=%06h", obs, F0);
        end
    endtask

    task automatic test_store();
        do_reset(32'd7);
        for (int i = 0; i < 16; i++) regs[i] = 32'd0;
        regs[1] = 32'd5;
        mem[7]  = mk(5'd2, 4'd1, 4'd0, 4'd0, 15'd90);
        mem[8]  = mk(5'd0, 4'd2, 4'd1, 4'd0, 15'd10);
        mem[15] = 32'h0000_1234;
        mem[90] = 32'd0;
        push("st_t0", F0); push("st_t1", F1); push("st_t2", F2); push("st_t3", M3);
        push("st_t4", M4); push("st_t5", M5); push("st_t6", ST6); push("st_next_t0", F0);
        drain(8);
        n_vec++;
        if (mem[90] !== 32'd5) begin
            n_mis++;
            $display("FAIL st_mem90: value=%0d required=5", mem[90]);
        end
        n_vec++;
        if (pc !== 32'd8) begin
            n_mis++;
            $display("FAIL st_pc: value=%0d required=8", pc);
        end
    endtask

    // Runs straight on from the store: its trailing T0 already fetched from PC=8
    task automatic test_back_to_back_load();
        push("ld_t1", F1); push("ld_t2", F2); push("ld_t3", M3); push("ld_t4", M4);
        push("ld_t5", M5); push("ld_t6", LD6); push("ld_t7", LD7); push("ld_next_t0", F0);
        drain(8);
        n_vec++;
        if (regs[2] !== 32'h0000_1234) begin
            n_mis++;
            $display("FAIL ld_r2: value=%08h required=00001234", regs[2]);
        end
    endtask

    task automatic test_alu();
        do_reset(32'd20);
        regs[2] = 32'd3; regs[3] = 32'd4;
        mem[20] = mk(5'd3,  4'd1, 4'd2, 4'd3, 15'd0);
        mem[21] = mk(5'd12, 4'd4, 4'd1, 4'd0, 15'd6);
        mem[22] = mk(5'd4,  4'd5, 4'd1, 4'd2, 15'd0);
        mem[23] = mk(5'd1,  4'd6, 4'd0, 4'd0, 15'd100);
        mem[24] = mk(5'd10, 4'd7, 4'd5, 4'd2, 15'd0);
        mem[25] = mk(5'd25, 4'd0, 4'd0, 4'd0, 15'd0);
        mem[26] = mk(5'd31, 4'd0, 4'd0, 4'd0, 15'd0);
        push("add_t0", F0); push("add_t1", F1); push("add_t2", F2); push("add_t3", A3);
        push("add_t4", K_GRC | K_ROUT | K_ADD | K_ZIN | K_RUN); push("add_t5", A5);
        push("andi_t0", F0); push("andi_t1", F1); push("andi_t2", F2); push("andi_t3", A3);
        push("andi_t4", K_COUT | K_AND | K_ZIN | K_RUN); push("andi_t5", A5);
        push("sub_t0", F0); push("sub_t1", F1); push("sub_t2", F2); push("sub_t3", A3);
        push("sub_t4", K_GRC | K_ROUT | K_SUB | K_ZIN | K_RUN); push("sub_t5", A5);
        push("ldi_t0", F0); push("ldi_t1", F1); push("ldi_t2", F2); push("ldi_t3", M3);
        push("ldi_t4", M4); push("ldi_t5", A5);
        push("or_t0", F0); push("or_t1", F1); push("or_t2", F2); push("or_t3", A3);
        push("or_t4", K_GRC | K_ROUT | K_OR | K_ZIN | K_RUN); push("or_t5", A5);
        push("nop_t0", F0); push("nop_t1", F1); push("nop_t2", F2); push("nop_t3", K_RUN);
        push("undef_t0", F0); push("undef_t1", F1); push("undef_t2", F2); push("undef_t3", K_RUN);
        push("alu_next_t0", F0);
        drain(6);
        n_vec++;
        if (regs[1] !== 32'd7) begin
            n_mis++;
            $display("FAIL add_r1: value=%0d required=7", regs[1]);
        end
        drain(33);
        n_vec++;
        if ({regs[4], regs[5], regs[6], regs[7]} !== {32'd6, 32'd4, 32'd100, 32'd7}) begin
            n_mis++;
            $display("FAIL alu_results: r4..r7=%0d,%0d,%0d,%0d required=6,4,100,7",
                     regs[4], regs[5], regs[6], regs[7]);
        end
    endtask

    task automatic test_halt();
        do_reset(32'd9);
        mem[9] = mk(5'd26, 4'd0, 4'd0, 4'd0, 15'd0);
        push("halt_t0", F0); push("halt_t1", F1); push("halt_t2", F2);
        push("halt_t3", K_IDLE);
        for (int i = 0; i < 20; i++) push("halted", K_IDLE);
        drain(24);
    endtask

    // stop is high from T0 on, so it must be ignored until the nop's final step
    task automatic test_pause();
        do_reset(32'd30);
        mem[30] = mk(5'd25, 4'd0, 4'd0, 4'd0, 15'd0);
        mem[31] = mk(5'd25, 4'd0, 4'd0, 4'd0, 15'd0);
        stop = 1'b1;
        push("pz_t0", F0); push("pz_t1", F1); push("pz_t2", F2); push("pz_t3", K_RUN);
        push("paused", K_IDLE); push("paused", K_IDLE); push("paused", K_IDLE);
        drain(7);
        stop = 1'b0;
        push("paused_last", K_IDLE); push("resume_t0", F0); push("resume_t1", F1);
        push("resume_t2", F2); push("resume_t3", K_RUN); push("resume_next_t0", F0);
        drain(6);
    endtask

    task automatic test_async_reset();
        do_reset(32'd40);
        mem[40] = mk(5'd0, 4'd7, 4'd0, 4'd0, 15'd50);
        push("ar_t0", F0); push("ar_t1", F1); push("ar_t2", F2); push("ar_t3", M3);
        push("ar_t4", M4);
        drain(5);
        #1;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (obs !== K_RUN) begin
            n_mis++;
            $display("FAIL ar_same_cycle: strobes=%06h required=%06h", obs, K_RUN);
        end
        push("ar_held", K_RUN);
        drain(1);
        n_vec++;
        if (mar !== 32'd40) begin
            n_mis++;
            $display("FAIL ar_mar: value=%0d required=40", mar);
        end
        rst_n = 1'b1;
        push("ar_release_t0", F0);
        drain(1);
    endtask

    initial begin
        pc = 32'd0; mar = 32'd0; mdr = 32'd0; y = 32'd0; z = 32'd0;
        for (int i = 0; i < 256; i++) mem[i] = 32'd0;
        for (int i = 0; i < 16; i++) regs[i] = 32'd0;
        test_reset();
        test_store();
        test_back_to_back_load();
        test_alu();
        test_halt();
        test_pause();
        test_async_reset();
        if (vec_q.size() != 0) begin
            n_vec++;
            n_mis++;
            $display("FAIL scoreboard_leftover: remaining=%0d required=0", vec_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-002 Port `clk`: input, 1 bit, system clock; all state changes occur on its rising edge.
REQ-003 Port `rst_n`: input, 1 bit, asynchronous active-low reset.
REQ-004 Port `ir`: input, 32 bits, instruction register contents; opcode is ir[31:27].
REQ-005 Port `stop`: input, 1 bit, request to pause before the next fetch.
REQ-006 Ports `PCout`, `PCin`, `IncPC`: outputs, 1 bit each; PC drives bus, PC loads, PC increments.
REQ-007 Ports `MARin`, `MDRin`, `MDRout`, `Read`, `Write`: outputs, 1 bit each; memory-path strobes.
REQ-008 Port `IRin`: output, 1 bit; IR loads from bus.
REQ-009 Ports `Gra`, `Grb`, `Grc`, `Rin`, `Rout`, `BAout`: outputs, 1 bit each; register-select and register-file strobes.
REQ-010 Ports `Yin`, `Zin`, `Zlowout`, `Cout`: outputs, 1 bit each; ALU operand, result and immediate strobes.
REQ-011 Ports `ADD`, `SUB`, `AND`, `OR`: outputs, 1 bit each; ALU operation select, one-hot or all zero.
REQ-012 Port `run`: output, 1 bit; 1 while the block is fetching or executing.

Function
REQ-013 Step states are T0–T7, plus PAUSE and HALT; every output is a Moore function of the state and ir[31:27].
REQ-014 Fetch: T0 asserts PCout, MARin, IncPC, Zin. T1 asserts Zlowout, PCin, Read, MDRin. T2 asserts MDRout, IRin. T2 always advances to T3.
REQ-015 Opcodes: ld=0, ldi=1, st=2, add=3, sub=4, and=9, or=10, addi=11, andi=12, ori=13, nop=25, halt=26.
REQ-016 Decode is taken from `ir` during T3 and later, never during T2.
REQ-017 ld: T3 Grb, BAout, Yin; T4 Cout, ADD, Zin; T5 Zlowout, MARin; T6 Read, MDRin; T7 MDRout, Gra, Rin; then T0. Total 8 cycles.
REQ-018 ldi: T3 and T4 as ld; T5 Zlowout, Gra, Rin; then T0. Total 6 cycles.
REQ-019 st: T3–T5 as ld; T6 Write, Gra, Rout, MDRin; then T0. Total 7 cycles.
REQ-020 Register ALU ops (add, sub, and, or): T3 Grb, Rout, Yin; T4 Grc, Rout, op, Zin; T5 Zlowout, Gra, Rin; then T0.
REQ-021 Immediate ALU ops (addi, andi, ori): as REQ-020, except T4 uses Cout in place of Grc and Rout.
REQ-022 nop and any undefined opcode: T3 asserts no strobes, then T0. Total 4 cycles.
REQ-023 halt: T3 goes to HALT; HALT asserts no strobes, sets run=0, and is left only by reset.
REQ-024 `stop` is sampled only in the final step of an instruction. If it is 1, the next state is PAUSE instead of T0.
REQ-025 PAUSE asserts no strobes and sets run=0. It returns to T0 on the first cycle `stop`=0.
REQ-026 Among Rout, BAout, PCout, MDRout, Zlowout and Cout, at most one is asserted in any cycle.
REQ-027 No step counter wraps past T7; an unreachable state encoding goes to T0.

Reset
REQ-028 When `rst_n`=0, the state is forced to T0 immediately, all strobes are 0 and run=1, regardless of `clk`.
REQ-029 Strobes stay 0 while `rst_n`=0. On the first rising edge after release, T0 strobes are active.
REQ-030 Reset asserted mid-instruction aborts the instruction; no further strobes of it are issued.

Structure
REQ-031 The shared proc definitions file holds the opcode constants and the state encoding; the datapath and benches use the same file.
REQ-032 The sub-module `op_decode` SHALL be combinational and map ir[31:27] to class flags: ld, ldi, st, alu_reg, alu_imm, nop, halt, plus the ALU op one-hot.

Verification
REQ-033 Store: PC=7, mem[7]={2,1,0,0,90}, R0=0, R1=5 -> strobes match REQ-019 in cycles 0–6; mem[90]=5; PC=8; T0 recurs at cycle 7.
REQ-034 Load: mem[8]={0,2,1,0,10}, R1=5, mem[15]=0x1234 -> R2=0x1234 after 8 cycles; Read is asserted in T1 and T6 only.
REQ-035 Add: R2=3, R3=4, IR=add R1,R2,R3 -> ADD is high only in T4; R1=7 after 6 cycles; SUB, AND and OR are never asserted.
REQ-036 Halt then stop: halt at PC=9 -> run=0 from T3 and no strobes for 20 cycles. Separately, stop=1 during a final step -> PAUSE; stop=0 -> T0 on the next edge.
REQ-037 Reset: rst_n=0 asserted asynchronously in ld T5 -> all strobes 0 in the same cycle; after release, T0 on the first edge and the MAR load from T5 is not completed.
REQ-038 Every scenario checks REQ-026 on every cycle.
